// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-arbiter bus: two requesters in, one framebuffer write port out.
interface fb_write_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
);
    logic              vblank;
    logic              a_req;
    logic              b_req;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              a_lock;
    logic              b_lock;
    logic              a_ack;
    logic              b_ack;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;

    // Requester/display side: drives requests, observes acks and the write port
    modport master (
        output vblank, a_req, b_req, a_addr, b_addr, a_data, b_data, a_lock, b_lock,
        input  a_ack, b_ack, we, waddr, wdata, busy
    );

    // Arbiter side
    modport slave (
        input  vblank, a_req, b_req, a_addr, b_addr, a_data, b_data, a_lock, b_lock,
        output a_ack, b_ack, we, waddr, wdata, busy
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Two-requester framebuffer write arbiter: round-robin with bounded burst lock,
// optional vblank-only granting, at most one write every two cycles.
module fb_write_arbiter #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 8,
    parameter bit          VBLANK_ONLY = 1'b0,
    parameter int unsigned MAX_LOCK    = 16
) (
    input  logic               clk,
    input  logic               rst,
    fb_write_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_n;
    logic               we_q, we_n;
    logic               a_ack_q, a_ack_n;
    logic               b_ack_q, b_ack_n;
    logic               busy_q, busy_n;
    logic [ADDR_W-1:0]  waddr_q, waddr_n;
    logic [DATA_W-1:0]  wdata_q, wdata_n;
    logic               last_b, last_b_n;
    logic               lock_flag, lock_flag_n;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_n;

    logic               elig_a, elig_b;
    logic               locked_regrant;
    logic               win_b;

    assign bus.we    = we_q;
    assign bus.a_ack = a_ack_q;
    assign bus.b_ack = b_ack_q;
    assign bus.busy  = busy_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;

    // Eligibility and winner selection (lock first, then round-robin, then single)
    always_comb begin
        elig_a         = bus.a_req && (!VBLANK_ONLY || bus.vblank);
        elig_b         = bus.b_req && (!VBLANK_ONLY || bus.vblank);
        locked_regrant = lock_flag && (lock_cnt < CNT_W'(MAX_LOCK)) &&
                         (last_b ? elig_b : elig_a);
        if (locked_regrant) begin
            win_b = last_b;
        end else if (elig_a && elig_b) begin
            win_b = !last_b;
        end else begin
            win_b = elig_b;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        we_n        = 1'b0;
        a_ack_n     = 1'b0;
        b_ack_n     = 1'b0;
        busy_n      = 1'b0;
        waddr_n     = waddr_q;
        wdata_n     = wdata_q;
        last_b_n    = last_b;
        lock_flag_n = lock_flag;
        lock_cnt_n  = lock_cnt;
        case (state)
            IDLE: begin
                if (elig_a || elig_b) begin
                    state_n     = GRANT;
                    we_n        = 1'b1;
                    busy_n      = 1'b1;
                    a_ack_n     = !win_b;
                    b_ack_n     = win_b;
                    waddr_n     = win_b ? bus.b_addr : bus.a_addr;
                    wdata_n     = win_b ? bus.b_data : bus.a_data;
                    last_b_n    = win_b;
                    lock_flag_n = win_b ? bus.b_lock : bus.a_lock;
                    if (locked_regrant) begin
                        lock_cnt_n = (lock_cnt == {CNT_W{1'b1}}) ? lock_cnt
                                                                 : lock_cnt + CNT_W'(1);
                    end else begin
                        lock_cnt_n = '0;
                    end
                end
            end
            GRANT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any write in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            last_b    <= 1'b1;
            lock_flag <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            state     <= state_n;
            we_q      <= we_n;
            a_ack_q   <= a_ack_n;
            b_ack_q   <= b_ack_n;
            busy_q    <= busy_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            last_b    <= last_b_n;
            lock_flag <= lock_flag_n;
            lock_cnt  <= lock_cnt_n;
        end
    end
endmodule
